// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared types and defaults for the vector register file
package vpu_pkg;

    localparam int unsigned NUM_REGS_DEFAULT     = 32;
    localparam int unsigned VLEN_DEFAULT         = 128;
    localparam int unsigned NUM_RD_PORTS_DEFAULT = 3;

    typedef logic [$clog2(NUM_REGS_DEFAULT)-1:0] VREG_t;

    typedef enum logic [1:0] {
        LMUL_1 = 2'd0,
        LMUL_2 = 2'd1,
        LMUL_4 = 2'd2,
        LMUL_8 = 2'd3
    } LMUL_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ERR    = 2'd2
    } rd_state_t;

    // Group size minus one: low-bit mask for alignment and the last-beat count.
    function automatic logic [2:0] group_mask(input LMUL_t lmul);
        case (lmul)
            LMUL_1:  return 3'd0;
            LMUL_2:  return 3'd1;
            LMUL_4:  return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/vrf_read_seq.sv
// rtl/vrf_read_seq.sv - per-port group read sequencer with registered output beat
module vrf_read_seq
    import vpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned VLEN     = VLEN_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [$clog2(NUM_REGS)-1:0] req_base_i,
    input  LMUL_t                       req_lmul_i,
    output logic [$clog2(NUM_REGS)-1:0] cur_idx_o,
    input  logic [VLEN-1:0]             cur_data_i,
    input  logic                        cur_busy_i,
    input  logic                        wb_en_i,
    input  logic                        wb_clr_i,
    input  logic [$clog2(NUM_REGS)-1:0] wb_index_i,
    input  logic [VLEN-1:0]             wb_data_i,
    input  logic [VLEN/8-1:0]           wb_be_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [VLEN-1:0]             rsp_data_o,
    output logic                        rsp_last_o,
    output logic                        rsp_err_o
);

    localparam int unsigned IW = $clog2(NUM_REGS);

    rd_state_t       state_q, state_d;
    logic [IW-1:0]   base_q, base_d;
    LMUL_t           lmul_q, lmul_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [VLEN-1:0] data_q, data_d;
    logic            last_q, last_d;
    logic            err_q, err_d;

    logic            fwd_hit;
    logic            clr_hit;
    logic            slot_free;
    logic            is_last;
    logic [VLEN-1:0] merged;

    assign cur_idx_o = base_q + IW'(cnt_q);
    assign fwd_hit   = wb_en_i && (wb_index_i == cur_idx_o);
    assign clr_hit   = fwd_hit && wb_clr_i;
    assign slot_free = !valid_q || rsp_ready_i;
    assign is_last   = (cnt_q == group_mask(lmul_q));

    // Write-first forwarding of the same-cycle writeback into the loaded beat.
    always_comb begin
        merged = cur_data_i;
        for (int k = 0; k < VLEN / 8; k++) begin
            if (fwd_hit && wb_be_i[k]) begin
                merged[8*k +: 8] = wb_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        lmul_d      = lmul_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q && !rsp_ready_i;
        data_d      = data_q;
        last_d      = last_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if ((req_base_i[2:0] & group_mask(req_lmul_i)) != 3'd0) begin
                        state_d = ERR;
                    end else begin
                        state_d = STREAM;
                        base_d  = req_base_i;
                        lmul_d  = req_lmul_i;
                        cnt_d   = 3'd0;
                    end
                end
            end
            STREAM: begin
                if (slot_free && (!cur_busy_i || clr_hit)) begin
                    valid_d = 1'b1;
                    data_d  = merged;
                    last_d  = is_last;
                    err_d   = 1'b0;
                    cnt_d   = cnt_q + 3'd1;
                    if (is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            ERR: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    data_d  = '0;
                    last_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            lmul_q  <= LMUL_1;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            lmul_q  <= lmul_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = data_q;
    assign rsp_last_o  = last_q;
    assign rsp_err_o   = err_q;

endmodule

// File: rtl/vector_regfile.sv
// rtl/vector_regfile.sv - VPU register array, byte-enabled writeback and busy scoreboard
module vector_regfile
    import vpu_pkg::*;
#(
    parameter int unsigned NUM_REGS     = NUM_REGS_DEFAULT,
    parameter int unsigned VLEN         = VLEN_DEFAULT,
    parameter int unsigned NUM_RD_PORTS = NUM_RD_PORTS_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wb_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] wb_index_i,
    input  logic [VLEN-1:0]             wb_data_i,
    input  logic [VLEN/8-1:0]           wb_be_i,
    input  logic                        wb_clr_i,
    input  logic                        sb_set_i,
    input  logic [$clog2(NUM_REGS)-1:0] sb_base_i,
    input  LMUL_t                       sb_lmul_i,
    output logic [NUM_REGS-1:0]         busy_o,
    input  logic [NUM_RD_PORTS-1:0]     rd_req_valid_i,
    output logic [NUM_RD_PORTS-1:0]     rd_req_ready_o,
    input  logic [$clog2(NUM_REGS)-1:0] rd_base_i [NUM_RD_PORTS],
    input  LMUL_t                       rd_lmul_i [NUM_RD_PORTS],
    output logic [NUM_RD_PORTS-1:0]     rd_rsp_valid_o,
    input  logic [NUM_RD_PORTS-1:0]     rd_rsp_ready_i,
    output logic [VLEN-1:0]             rd_rsp_data_o [NUM_RD_PORTS],
    output logic [NUM_RD_PORTS-1:0]     rd_rsp_last_o,
    output logic [NUM_RD_PORTS-1:0]     rd_rsp_err_o
);

    localparam int unsigned IW = $clog2(NUM_REGS);

    logic [VLEN-1:0]     regs_q [NUM_REGS];
    logic [VLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                sb_aligned;
    logic [IW-1:0]       cur_idx [NUM_RD_PORTS];

    always_comb begin
        regs_d = regs_q;
        if (wb_en_i) begin
            for (int k = 0; k < VLEN / 8; k++) begin
                if (wb_be_i[k]) begin
                    regs_d[wb_index_i][8*k +: 8] = wb_data_i[8*k +: 8];
                end
            end
        end
    end

    assign sb_aligned = (sb_base_i[2:0] & group_mask(sb_lmul_i)) == 3'd0;

    // Set is applied after clear so it wins on a same-register collision.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i && wb_clr_i) begin
            busy_d[wb_index_i] = 1'b0;
        end
        if (sb_set_i && sb_aligned) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) <= group_mask(sb_lmul_i)) begin
                    busy_d[sb_base_i + IW'(i)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        vrf_read_seq #(
            .NUM_REGS (NUM_REGS),
            .VLEN     (VLEN)
        ) u_seq (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .req_valid_i (rd_req_valid_i[p]),
            .req_ready_o (rd_req_ready_o[p]),
            .req_base_i  (rd_base_i[p]),
            .req_lmul_i  (rd_lmul_i[p]),
            .cur_idx_o   (cur_idx[p]),
            .cur_data_i  (regs_q[cur_idx[p]]),
            .cur_busy_i  (busy_q[cur_idx[p]]),
            .wb_en_i     (wb_en_i),
            .wb_clr_i    (wb_clr_i),
            .wb_index_i  (wb_index_i),
            .wb_data_i   (wb_data_i),
            .wb_be_i     (wb_be_i),
            .rsp_valid_o (rd_rsp_valid_o[p]),
            .rsp_ready_i (rd_rsp_ready_i[p]),
            .rsp_data_o  (rd_rsp_data_o[p]),
            .rsp_last_o  (rd_rsp_last_o[p]),
            .rsp_err_o   (rd_rsp_err_o[p])
        );
    end

endmodule

// File: doc/vector_regfile.md
Name: vector_regfile

Overview:
- Parametrised successor of the scalar CPU register file, serving the VPU.
- NUM_REGS x VLEN-bit registers with one byte-enabled writeback port.
- NUM_RD_PORTS independent read ports; each streams a register group (LMUL 1/2/4/8) one register per beat over a valid/ready handshake.
- An integrated busy-bit scoreboard stalls reads of registers with pending writes and forwards writeback data write-first.

Parameters:
- NUM_REGS, 32, register count; power of two, >= 8.
- VLEN, 128, register width in bits; multiple of 8.
- NUM_RD_PORTS, 3, independent read ports (vs1, vs2, vd-old/mask).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_en_i  in  1  writeback enable.
- wb_index_i  in  VREG_t  writeback register.
- wb_data_i  in  VLEN  writeback data.
- wb_be_i  in  VLEN/8  byte enables; bit k covers bits 8k+7:8k.
- wb_clr_i  in  1  with wb_en_i, clears busy[wb_index_i].
- sb_set_i  in  1  mark a register group busy.
- sb_base_i  in  VREG_t  group base.
- sb_lmul_i  in  LMUL_t  group size, log2.
- busy_o  out  NUM_REGS  scoreboard state.
- rd_req_valid_i  in  [NUM_RD_PORTS]  read request.
- rd_req_ready_o  out  [NUM_RD_PORTS]  port idle.
- rd_base_i  in  [NUM_RD_PORTS] VREG_t  group base.
- rd_lmul_i  in  [NUM_RD_PORTS] LMUL_t  group size, log2.
- rd_rsp_valid_o  out  [NUM_RD_PORTS]  beat valid.
- rd_rsp_ready_i  in  [NUM_RD_PORTS]  beat accepted.
- rd_rsp_data_o  out  [NUM_RD_PORTS][VLEN]  beat data, registered.
- rd_rsp_last_o  out  [NUM_RD_PORTS]  final beat of the group.
- rd_rsp_err_o  out  [NUM_RD_PORTS]  misaligned request.

Behaviour:
- Reset (asynchronous): all registers, busy_o, rsp_data_o, rsp_valid_o, rsp_last_o and rsp_err_o go to 0. rd_req_ready_o = 1. All read FSMs go to IDLE. Reset mid-stream abandons the group.
- Write: at posedge with wb_en_i, byte k of reg[wb_index_i] is updated where wb_be_i[k]=1. There is no hardwired zero register; v0 is writable.
- Scoreboard next-state:
  - sb_set_i sets busy[sb_base_i .. sb_base_i + 2^sb_lmul_i - 1].
  - wb_en_i && wb_clr_i clears busy[wb_index_i].
  - Set and clear on the same register in the same cycle: set wins.
  - sb_set_i with a misaligned base is ignored.
- Read FSM, per port: IDLE -> STREAM, or IDLE -> ERR.
  - IDLE: ready = 1. On a valid request:
    - If rd_base_i mod 2^lmul != 0, go to ERR.
    - Otherwise latch base and lmul, set cnt = 0, go to STREAM.
  - STREAM: ready = 0. cur = base + cnt; alignment guarantees no wrap.
    - The output register loads when it is empty or its beat is handshaking this cycle, AND (!busy[cur] OR (wb_en_i && wb_clr_i && wb_index_i == cur)).
    - Loaded data is reg[cur] merged with wb_data_i per wb_be_i when wb_en_i && wb_index_i == cur (write-first forwarding, busy or not).
    - A load sets valid = 1, last = (cnt == 2^lmul - 1), then cnt++.
    - After the load with last = 1, the FSM goes to IDLE. The output register drains independently.
    - A new request may be accepted in IDLE while the final beat is still held; the first beat of the new request loads only once the held beat handshakes.
  - ERR: loads one beat with data = 0, err = 1, last = 1, then goes to IDLE.
  - Output stability: while valid && !ready, data, last and err hold stable, even if the register is written meanwhile.
  - Output register: valid clears on handshake unless a new beat loads in the same cycle.
- Latency: request accepted at edge T; earliest first beat valid after edge T+1. With no stalls, a group of N registers completes in N+1 cycles.
- Ports never block each other. Reads observe the array after the prior edge plus the forwarding above.

Decomposition:
- vpu_pkg contains:
  - VREG_t = logic [$clog2(NUM_REGS)-1:0].
  - LMUL_t, a 2-bit enum: LMUL_1, LMUL_2, LMUL_4, LMUL_8.
  - rd_state_t enum: IDLE, STREAM, ERR.
  - Default VLEN constant.
- Sub-module vrf_read_seq:
  - One FSM, counter and output register per port, instantiated in a generate loop.
  - Receives the array read data, the busy bit and the wb forwarding signals for its cur index.
- The top level holds the register array, the byte-enable write logic and the scoreboard.

Test Plan:
- Reset check: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately, ready = 1. After release, read v5 with lmul 0 -> one beat of data 0 with last = 1.
- Byte-enable write: write v3 = all-ones with be = all-ones, then write v3 = 0 with be = 16'h00FF. Read v3 -> 128'hFFFF...FF_0000_0000_0000_0000.
- Group read with backpressure: preload v8..v11 with 8, 9, 10, 11. Request base 8, lmul 2 with rsp_ready toggling 1,0,0,1 -> four beats 8, 9, 10, 11, data stable while stalled, last only on beat 11.
- Scoreboard stall and forwarding: sb_set base 4, lmul 1 -> busy_o[5:4] = 2'b11. Read base 4 stalls with valid = 0. wb v4 = 32'hA5 with clr -> beat v4 = 32'hA5 in the same load cycle. v5 stays stalled until its clr.
- Misaligned request: request base 6, lmul 2 -> single beat with err = 1, last = 1, data 0, then ready = 1. The sb_set on base 6, lmul 2 leaves busy_o unchanged.
- Set/clear collision: sb_set base 2, lmul 0 in the same cycle as wb_clr on v2 -> busy_o[2] = 1. All three ports reading v2 concurrently all stall.
